data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Responder end of the CPU data-memory class-SRAM interface that mycpu_top produces from the execute stage's simple data_sram port.
- Accepts read/write requests on an address handshake and holds a word-organised data RAM. Returns completion in order on a data handshake after a programmable latency.
- Used as the on-chip data memory in simulation/FPGA builds and as the slave model for pipeline load/store verification.

Parameters:
- ADDR_W, 10, word-index width; memory has 2^ADDR_W 32-bit words.
- LATENCY, 2, minimum cycles from request acceptance to data_ok (legal 1..15).
- MAX_OUT, 2, maximum outstanding accepted-but-not-completed requests (legal 1..4).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  00 byte, 01 half, 10 word.
- wstrb  in  4  byte enables for writes; ignored for reads.
- addr  in  32  byte address.
- wdata  in  32  write data, byte lanes already replicated by requester.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one-cycle completion pulse, oldest outstanding request.
- rdata  out  32  read word, valid when data_ok for a read; 0 otherwise.

Behaviour:
- Reset values (async assert): addr_ok=0 while reset high; data_ok=0; rdata=0; outstanding count=0; FIFO pointers=0; cycle counter=0. Memory contents are NOT reset.
- addr_ok = !reset && (count < MAX_OUT). Purely registered-state based; no same-cycle dependence on retirement.
- Acceptance (req && addr_ok):
  - Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W words. addr[1:0] is not checked and size does not affect storage.
  - Write: at this edge, bytes with wstrb[i]=1 take wdata[8i+7:8i]; other bytes are unchanged. wstrb=0000 writes nothing but still completes.
  - Read: the full word is sampled at this edge, after any earlier writes. Read-after-write to the same word returns the new data even when both are outstanding.
  - Push {wr, sampled word, stamp = cycle counter} into the FIFO; count increments.
- Cycle counter: 8-bit free-running. Age = (counter - stamp) mod 256, always below 256 because LATENCY<=15.
- Completion:
  - Head entry retires when count>0 and age >= LATENCY.
  - Registered outputs: data_ok=1 and rdata = word (read) or 0 (write) in the cycle after the retire decision. Net result: data_ok rises exactly LATENCY cycles after the accepting edge when there is no queuing.
  - At most one completion per cycle, in acceptance order. No backpressure on data_ok; the requester must consume it.
- Throughput: with MAX_OUT > LATENCY, one request per cycle is sustained. Otherwise addr_ok drops while count==MAX_OUT.
- Simultaneous push and retire in one cycle: count unchanged, both pointers advance.
- When full, addr_ok=0 even in a cycle where the head retires; it re-asserts the following cycle.
- Requests held while addr_ok=0 are not accepted or recorded. The requester holds req and fields stable.
- Reset mid-operation:
  - All outstanding entries are discarded and no data_ok is issued for them.
  - Writes already accepted remain in memory.
  - After deassertion, addr_ok=1 on the first cycle.
- Memory write and read on the same edge happen only via a single accepted request, so there is no port conflict.

Test Plan:
- Reset, then write word addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 1111. Then read 0x10 with LATENCY=2 -> data_ok exactly 2 cycles after each accept; read rdata=0xDEADBEEF; write completion rdata=0.
- Write 0x11223344 to 0x20, then st.b wstrb 0100 with wdata 0xAAAAAAAA at 0x22, then read 0x20 -> rdata=0x11AA3344.
- Back-to-back read, read, read with MAX_OUT=2, LATENCY=2 -> addr_ok low on 3rd request cycle; third accepted next cycle; three data_ok pulses in order with correct words.
- Write 0x5 to 0x40 followed immediately by read 0x40 with the write still outstanding -> read returns 0x00000005.
- Address wrap with ADDR_W=10: write 0xCAFEF00D to 0x0000_1004 -> read 0x0000_0004 returns 0xCAFEF00D.
- Assert reset with 2 outstanding reads, deassert -> no data_ok for them; addr_ok=1 first cycle after; previously accepted writes still readable.

Source files
------------

// File: rtl/data_sram_responder.sv
// Responder for the CPU data-SRAM handshake: word-organised RAM with in-order,
// fixed-minimum-latency completions tracked by a small timestamped FIFO.
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam int              PW      = 2;
    localparam int              CW      = 3;
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUT);
    localparam logic [PW-1:0]   LAST    = PW'(MAX_OUT - 1);
    localparam logic [7:0]      LAT8    = 8'(LATENCY);

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;
    logic              accept;
    logic              retire;
    logic [7:0]        age;

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [7:0]        cyc_q;
    logic              data_ok_q;
    logic [31:0]       rdata_q, rdata_d;

    // Sized for the largest legal MAX_OUT; only MAX_OUT entries are used.
    logic              fifo_wr_q    [4];
    logic [31:0]       fifo_word_q  [4];
    logic [7:0]        fifo_stamp_q [4];

    logic              unused_bits;
    assign unused_bits = ^{size_i, addr_i[31:ADDR_W+2], addr_i[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign addr_ok_o = !reset_i && (count_q < MAX_CNT);
    assign accept    = req_i && addr_ok_o;
    assign idx       = addr_i[ADDR_W+1:2];
    assign rd_word   = mem_q[idx];

    assign age    = cyc_q - fifo_stamp_q[rptr_q];
    assign retire = (count_q != '0) && (age >= LAT8);

    always_comb begin
        count_d = count_q;
        case ({accept, retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        wptr_d  = accept ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = retire ? ptr_inc(rptr_q) : rptr_q;
        rdata_d = (retire && !fifo_wr_q[rptr_q]) ? fifo_word_q[rptr_q] : '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cyc_q     <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cyc_q     <= cyc_q + 8'd1;
            data_ok_q <= retire;
            rdata_q   <= rdata_d;
        end
    end

    // Payload storage is not reset: entries are only read when count says valid.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_wr_q[wptr_q]    <= wr_i;
            fifo_word_q[wptr_q]  <= rd_word;
            fifo_stamp_q[wptr_q] <= cyc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && wr_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) mem_q[idx][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign data_ok_o = data_ok_q;
    assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with default parameters
// (ADDR_W=10, LATENCY=2, MAX_OUT=2); checks are sampled on the falling edge.
module tb_data_sram_responder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_i;
    logic        wr_i;
    logic [1:0]  size_i;
    logic [3:0]  wstrb_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        addr_ok_o;
    logic        data_ok_o;
    logic [31:0] rdata_o;

    int total = 0;
    int bad   = 0;

    data_sram_responder dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .wr_i      (wr_i),
        .size_i    (size_i),
        .wstrb_i   (wstrb_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .addr_ok_o (addr_ok_o),
        .data_ok_o (data_ok_o),
        .rdata_o   (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and hold it until the falling edge after acceptance.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int   n;
        logic ok;
        req_i   = 1'b1;
        wr_i    = w;
        addr_i  = a;
        wdata_i = d;
        wstrb_i = s;
        size_i  = 2'b10;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            if (addr_ok_o) ok = 1'b1;
            @(negedge clk_i);
            n++;
        end
        chk("accepted", {31'd0, ok}, 32'd1);
    endtask

    // Called on the falling edge right after the accepting edge; n counts rising
    // edges since acceptance.
    task automatic expect_done(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!data_ok_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd2);
        chk({tag, " rdata"}, rdata_o, exp);
    endtask

    initial begin
        logic seen;
        reset_i = 1'b1;
        req_i   = 1'b0;
        wr_i    = 1'b0;
        size_i  = 2'b10;
        wstrb_i = 4'h0;
        addr_i  = '0;
        wdata_i = '0;

        @(negedge clk_i);
        chk("rst addr_ok", {31'd0, addr_ok_o}, 32'd0);
        chk("rst data_ok", {31'd0, data_ok_o}, 32'd0);
        chk("rst rdata", rdata_o, 32'd0);
        reset_i = 1'b0;
        #1;
        chk("post-rst addr_ok", {31'd0, addr_ok_o}, 32'd1);

        // basic write then read
        issue(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF);
        req_i = 1'b0;
        expect_done("wr10", 32'h0);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        req_i = 1'b0;
        expect_done("rd10", 32'hDEADBEEF);

        // byte-lane merge
        issue(1'b1, 32'h0000_0020, 32'h11223344, 4'hF);
        req_i = 1'b0;
        expect_done("wr20", 32'h0);
        issue(1'b1, 32'h0000_0022, 32'hAAAAAAAA, 4'b0100);
        req_i = 1'b0;
        expect_done("stb22", 32'h0);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        req_i = 1'b0;
        expect_done("rd20", 32'h11AA3344);

        // zero strobe completes but leaves memory alone
        issue(1'b1, 32'h0000_0010, 32'h12345678, 4'h0);
        req_i = 1'b0;
        expect_done("wr0strb", 32'h0);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        req_i = 1'b0;
        expect_done("rd0strb", 32'hDEADBEEF);

        // read-after-write with the write still outstanding
        issue(1'b1, 32'h0000_0040, 32'h00000005, 4'hF);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        req_i = 1'b0;
        @(negedge clk_i);
        chk("raw wr done", {31'd0, data_ok_o}, 32'd1);
        chk("raw wr rdata", rdata_o, 32'h0);
        @(negedge clk_i);
        chk("raw rd done", {31'd0, data_ok_o}, 32'd1);
        chk("raw rd rdata", rdata_o, 32'h00000005);

        // address wrap modulo 2^10 words
        issue(1'b1, 32'h0000_1004, 32'hCAFEF00D, 4'hF);
        req_i = 1'b0;
        expect_done("wrap wr", 32'h0);
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        req_i = 1'b0;
        expect_done("wrap rd", 32'hCAFEF00D);

        // three back-to-back reads against MAX_OUT=2
        @(negedge clk_i);
        req_i  = 1'b1;
        wr_i   = 1'b0;
        addr_i = 32'h0000_0010;
        @(negedge clk_i);
        chk("b2b ok1", {31'd0, addr_ok_o}, 32'd1);
        addr_i = 32'h0000_0020;
        @(negedge clk_i);
        chk("b2b full", {31'd0, addr_ok_o}, 32'd0);
        chk("b2b early done", {31'd0, data_ok_o}, 32'd0);
        addr_i = 32'h0000_0040;
        @(negedge clk_i);
        chk("b2b done A", {31'd0, data_ok_o}, 32'd1);
        chk("b2b rdata A", rdata_o, 32'hDEADBEEF);
        chk("b2b reopen", {31'd0, addr_ok_o}, 32'd1);
        @(negedge clk_i);
        req_i = 1'b0;
        chk("b2b done B", {31'd0, data_ok_o}, 32'd1);
        chk("b2b rdata B", rdata_o, 32'h11AA3344);
        @(negedge clk_i);
        chk("b2b gap", {31'd0, data_ok_o}, 32'd0);
        @(negedge clk_i);
        chk("b2b done C", {31'd0, data_ok_o}, 32'd1);
        chk("b2b rdata C", rdata_o, 32'h00000005);

        // reset with two reads outstanding
        @(negedge clk_i);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        req_i   = 1'b0;
        reset_i = 1'b1;
        #1;
        chk("midrst addr_ok", {31'd0, addr_ok_o}, 32'd0);
        chk("midrst data_ok", {31'd0, data_ok_o}, 32'd0);
        chk("midrst rdata", rdata_o, 32'h0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            seen = seen | data_ok_o;
        end
        reset_i = 1'b0;
        #1;
        chk("rst exit addr_ok", {31'd0, addr_ok_o}, 32'd1);
        repeat (6) begin
            @(negedge clk_i);
            seen = seen | data_ok_o;
        end
        chk("no stale data_ok", {31'd0, seen}, 32'd0);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        req_i = 1'b0;
        expect_done("keep 40", 32'h00000005);
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        req_i = 1'b0;
        expect_done("keep 04", 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
